// File: rtl/mem_dbus_ctrl_if.sv
// mem_dbus_ctrl_if
//   Data-bus bundle between the MEM-stage bus controller (master) and the
//   memory/bus fabric (slave). A transaction is open while bus_req is high
//   and completes on the cycle bus_ack is seen high.
//
//   bus_req    master->slave  request, held until bus_ack
//   bus_we     master->slave  1 = write
//   bus_addr   master->slave  word-aligned byte address
//   bus_sel    master->slave  byte lanes, bus_sel[3] = bits[31:24]
//   bus_wdata  master->slave  store data replicated into addressed lanes
//   bus_rdata  slave->master  read data, valid with bus_ack
//   bus_ack    slave->master  completes the transaction
interface mem_dbus_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl
//   MEM-stage data-bus controller sitting directly upstream of the MEM/WB
//   register. Turns load/store/LL/SC requests from EX/MEM into a req/ack bus
//   transaction, holds the pipeline with stallreq until it completes, aligns
//   and extends big-endian load data and produces the write-back fields.
//
//   clk, rst        clock, synchronous active-high reset
//   flush           exception flush, squashes the current op
//   in_wd/in_wreg/in_wdata   write-back fields from EX/MEM (non-memory ops)
//   mem_op          0 none,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW,9 LL,10 SC
//   mem_addr        effective byte address
//   mem_sdata       store data (rt)
//   llbit_in        current LLbit (forwarded)
//   bus             data-bus master modport
//   stallreq        pipeline hold request
//   out_wd/out_wreg/out_wdata, out_llbit_we/out_llbit_v   to MEM/WB
//   excp_adel/excp_ades      misaligned load / store
//   bus_err         one-cycle pulse when a transaction times out
module mem_dbus_ctrl #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [4:0]             in_wd,
    input  logic                   in_wreg,
    input  logic [31:0]            in_wdata,
    input  logic [3:0]             mem_op,
    input  logic [31:0]            mem_addr,
    input  logic [31:0]            mem_sdata,
    input  logic                   llbit_in,
    mem_dbus_ctrl_if.master        bus,
    output logic                   stallreq,
    output logic [4:0]             out_wd,
    output logic                   out_wreg,
    output logic [31:0]            out_wdata,
    output logic                   out_llbit_we,
    output logic                   out_llbit_v,
    output logic                   excp_adel,
    output logic                   excp_ades,
    output logic                   bus_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic       ld;
        logic       st;
        logic       ll;
        logic       sc;
        logic       sgn;
        logic [1:0] size;   // 0 byte, 1 half, 2 word
    } dec_t;

    function automatic dec_t decode(input logic [3:0] op);
        dec_t d;
        d = '0;
        case (op)
            4'd1:  begin d.ld = 1'b1; d.sgn = 1'b1; d.size = 2'd0; end
            4'd2:  begin d.ld = 1'b1;               d.size = 2'd0; end
            4'd3:  begin d.ld = 1'b1; d.sgn = 1'b1; d.size = 2'd1; end
            4'd4:  begin d.ld = 1'b1;               d.size = 2'd1; end
            4'd5:  begin d.ld = 1'b1;               d.size = 2'd2; end
            4'd6:  begin d.st = 1'b1;               d.size = 2'd0; end
            4'd7:  begin d.st = 1'b1;               d.size = 2'd1; end
            4'd8:  begin d.st = 1'b1;               d.size = 2'd2; end
            4'd9:  begin d.ld = 1'b1; d.ll = 1'b1;  d.size = 2'd2; end
            4'd10: begin d.st = 1'b1; d.sc = 1'b1;  d.size = 2'd2; end
            default: ;
        endcase
        return d;
    endfunction

    localparam int unsigned    CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]  TMO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          bus_req_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [3:0]    sel_q;
    logic [31:0]   wdata_q;
    logic [4:0]    wd_q;
    logic [1:0]    off_q;
    logic          ld_q, ll_q, sc_q, sgn_q;
    logic [1:0]    size_q;
    logic [31:0]   result_q, result_d;
    logic [CW-1:0] cnt_q;
    logic          bus_err_q, err_d;

    // Input-side decode
    dec_t        dec_in;
    logic [1:0]  off_in;
    logic        is_mem, sc_fail, misal, start_ok;
    logic [3:0]  sel_in;
    logic [31:0] wdata_in;
    logic        tmo_hit, start, enter_wait;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin : in_decode
        dec_in   = decode(mem_op);
        off_in   = mem_addr[1:0];
        is_mem   = dec_in.ld | dec_in.st;
        sc_fail  = dec_in.sc & ~llbit_in;
        misal    = ((dec_in.size == 2'd1) & off_in[0]) |
                   ((dec_in.size == 2'd2) & (off_in != 2'b00));
        start_ok = is_mem & ~misal & ~sc_fail;
        case (dec_in.size)
            2'd0:    sel_in = 4'b1000 >> off_in;
            2'd1:    sel_in = off_in[1] ? 4'b0011 : 4'b1100;
            default: sel_in = 4'b1111;
        endcase
        case (dec_in.size)
            2'd0:    wdata_in = {4{mem_sdata[7:0]}};
            2'd1:    wdata_in = {2{mem_sdata[15:0]}};
            default: wdata_in = mem_sdata;
        endcase
    end

    // Big-endian lane extraction and extension of the returning read data
    always_comb begin : load_align
        case (off_q)
            2'd0:    byte_v = bus.bus_rdata[31:24];
            2'd1:    byte_v = bus.bus_rdata[23:16];
            2'd2:    byte_v = bus.bus_rdata[15:8];
            default: byte_v = bus.bus_rdata[7:0];
        endcase
        half_v   = off_q[1] ? bus.bus_rdata[15:0] : bus.bus_rdata[31:16];
        result_d = '0;
        if (sc_q) begin
            result_d = 32'd1;
        end else if (ld_q) begin
            case (size_q)
                2'd0:    result_d = sgn_q ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
                2'd1:    result_d = sgn_q ? {{16{half_v[15]}}, half_v} : {16'h0, half_v};
                default: result_d = bus.bus_rdata;
            endcase
        end
    end

    assign tmo_hit = (TIMEOUT != 0) && (cnt_q == TMO_LAST);

    // Next-state logic
    always_comb begin : next_state
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // The cycle after a timeout the faulted op is still presented;
                // it is treated as squashed so it cannot re-issue.
                if (!flush && !bus_err_q && start_ok)
                    state_d = S_BUSY;
            end
            S_BUSY: begin
                if (bus.bus_ack)
                    state_d = flush ? S_IDLE : S_DONE;
                else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (flush)
                    state_d = S_DRAIN;
            end
            S_DONE: state_d = S_IDLE;
            S_DRAIN: begin
                if (bus.bus_ack)
                    state_d = S_IDLE;
                else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign start      = (state_q == S_IDLE) && (state_d == S_BUSY);
    assign enter_wait = (state_d != state_q) && ((state_d == S_BUSY) || (state_d == S_DRAIN));

    // State and datapath registers
    always_ff @(posedge clk) begin : regs
        if (rst) begin
            state_q   <= S_IDLE;
            bus_req_q <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            sel_q     <= '0;
            wdata_q   <= '0;
            wd_q      <= '0;
            off_q     <= '0;
            ld_q      <= 1'b0;
            ll_q      <= 1'b0;
            sc_q      <= 1'b0;
            sgn_q     <= 1'b0;
            size_q    <= '0;
            result_q  <= '0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_req_q <= (state_d == S_BUSY) || (state_d == S_DRAIN);
            bus_err_q <= err_d;
            if (start) begin
                we_q    <= dec_in.st;
                addr_q  <= {mem_addr[31:2], 2'b00};
                sel_q   <= sel_in;
                wdata_q <= wdata_in;
                wd_q    <= in_wd;
                off_q   <= off_in;
                ld_q    <= dec_in.ld;
                ll_q    <= dec_in.ll;
                sc_q    <= dec_in.sc;
                sgn_q   <= dec_in.sgn;
                size_q  <= dec_in.size;
            end
            if (state_q == S_BUSY && bus.bus_ack)
                result_q <= result_d;
            if (enter_wait)
                cnt_q <= '0;
            else if (state_q == S_BUSY || state_q == S_DRAIN)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // Output logic
    always_comb begin : outputs
        stallreq     = 1'b0;
        out_wd       = '0;
        out_wreg     = 1'b0;
        out_wdata    = '0;
        out_llbit_we = 1'b0;
        out_llbit_v  = 1'b0;
        excp_adel    = 1'b0;
        excp_ades    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE, S_DRAIN: begin
                    out_wd = in_wd;
                    if (!flush && !bus_err_q) begin
                        if (!is_mem) begin
                            out_wreg  = in_wreg;
                            out_wdata = in_wdata;
                        end else if (sc_fail) begin
                            out_wreg = 1'b1;
                        end else if (misal) begin
                            excp_adel = dec_in.ld;
                            excp_ades = dec_in.st;
                        end else begin
                            stallreq = 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    out_wd   = wd_q;
                    stallreq = 1'b1;
                end
                S_DONE: begin
                    out_wd = wd_q;
                    if (!flush) begin
                        out_wreg     = ld_q | sc_q;
                        out_wdata    = result_q;
                        out_llbit_we = ll_q | sc_q;
                        out_llbit_v  = ll_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_wdata = wdata_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
module tb_mem_dbus_ctrl;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [4:0]  in_wd;
    logic        in_wreg;
    logic [31:0] in_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr, mem_sdata;
    logic        llbit_in;
    logic        stallreq, out_wreg, out_llbit_we, out_llbit_v;
    logic [4:0]  out_wd;
    logic [31:0] out_wdata;
    logic        excp_adel, excp_ades, bus_err;

    int checks   = 0;
    int failures = 0;

    mem_dbus_ctrl_if bus_if ();

    mem_dbus_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_wd(in_wd), .in_wreg(in_wreg), .in_wdata(in_wdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .llbit_in(llbit_in), .bus(bus_if),
        .stallreq(stallreq), .out_wd(out_wd), .out_wreg(out_wreg),
        .out_wdata(out_wdata), .out_llbit_we(out_llbit_we),
        .out_llbit_v(out_llbit_v), .excp_adel(excp_adel),
        .excp_ades(excp_ades), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; mem_op = 4'd0; mem_addr = '0; mem_sdata = '0; llbit_in = 0;
        in_wd = '0; in_wreg = 0; in_wdata = '0;
        bus_if.bus_ack = 0; bus_if.bus_rdata = '0;
    endtask

    // One full aligned access; ack given in the (ack_after+1)-th request cycle.
    task automatic access(input string nm, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic llb, input int ack_after,
                          input logic [31:0] rdata, input int exp_stall,
                          input logic exp_we, input logic [3:0] exp_sel, input logic [31:0] exp_bwd,
                          input logic exp_wreg, input logic [31:0] exp_wdata,
                          input logic exp_llwe, input logic exp_llv);
        int  stall_cnt = 0;
        int  req_cnt   = 0;
        bit  prev_stall = 0;
        bit  done = 0;
        @(negedge clk);
        mem_op = op; mem_addr = addr; mem_sdata = sdata; llbit_in = llb; in_wd = 5'd9;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (stallreq) stall_cnt++;
            if (bus_if.bus_req) begin
                if (req_cnt == 0) begin
                    chk({nm, " bus_addr"}, bus_if.bus_addr, {addr[31:2], 2'b00});
                    chk({nm, " bus_we"}, 32'(bus_if.bus_we), 32'(exp_we));
                    if (exp_we) begin
                        chk({nm, " bus_sel"}, 32'(bus_if.bus_sel), 32'(exp_sel));
                        chk({nm, " bus_wdata"}, bus_if.bus_wdata, exp_bwd);
                    end
                end
                if (req_cnt == ack_after) begin
                    bus_if.bus_ack = 1; bus_if.bus_rdata = rdata;
                end
                req_cnt++;
            end
            if (prev_stall && !stallreq) begin
                done = 1;
                chk({nm, " out_wreg"}, 32'(out_wreg), 32'(exp_wreg));
                if (exp_wreg) chk({nm, " out_wdata"}, out_wdata, exp_wdata);
                chk({nm, " out_wd"}, 32'(out_wd), 32'd9);
                chk({nm, " llbit_we"}, 32'(out_llbit_we), 32'(exp_llwe));
                chk({nm, " llbit_v"}, 32'(out_llbit_v), 32'(exp_llv));
                chk({nm, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
            end
            prev_stall = stallreq;
            @(negedge clk);
            bus_if.bus_ack = 0;
        end
        if (!done) chk({nm, " completion bound"}, 32'd0, 32'd1);
        idle_inputs();
    endtask

    typedef struct {
        logic flush; logic [3:0] op; logic [31:0] addr; logic llb;
        logic [4:0] wd; logic wreg; logic [31:0] wdata;
        logic e_stall; logic e_wreg; logic [31:0] e_wdata;
        logic e_adel; logic e_ades; logic e_llwe;
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{0, 4'd0,  32'h100, 0, 5'd5, 1, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 0, 0};
        vecs[1]  = '{0, 4'd11, 32'h101, 0, 5'd7, 1, 32'h12345678, 0, 1, 32'h12345678, 0, 0, 0};
        vecs[2]  = '{0, 4'd0,  32'h000, 0, 5'd3, 0, 32'hAAAA5555, 0, 0, 32'h0,        0, 0, 0};
        vecs[3]  = '{0, 4'd5,  32'h101, 0, 5'd1, 1, 32'h99,       0, 0, 32'h0,        1, 0, 0};
        vecs[4]  = '{0, 4'd3,  32'h101, 0, 5'd1, 1, 32'h99,       0, 0, 32'h0,        1, 0, 0};
        vecs[5]  = '{0, 4'd4,  32'h103, 0, 5'd1, 1, 32'h99,       0, 0, 32'h0,        1, 0, 0};
        vecs[6]  = '{0, 4'd9,  32'h102, 0, 5'd1, 1, 32'h99,       0, 0, 32'h0,        1, 0, 0};
        vecs[7]  = '{0, 4'd8,  32'h102, 0, 5'd1, 1, 32'h99,       0, 0, 32'h0,        0, 1, 0};
        vecs[8]  = '{0, 4'd7,  32'h101, 0, 5'd1, 1, 32'h99,       0, 0, 32'h0,        0, 1, 0};
        vecs[9]  = '{0, 4'd10, 32'h101, 1, 5'd1, 1, 32'h99,       0, 0, 32'h0,        0, 1, 0};
        vecs[10] = '{0, 4'd10, 32'h101, 0, 5'd2, 1, 32'h99,       0, 1, 32'h0,        0, 0, 0};
        vecs[11] = '{0, 4'd10, 32'h100, 0, 5'd2, 1, 32'h99,       0, 1, 32'h0,        0, 0, 0};
        vecs[12] = '{0, 4'd4,  32'h102, 0, 5'd4, 1, 32'h99,       1, 0, 32'h0,        0, 0, 0};
        vecs[13] = '{0, 4'd1,  32'h103, 0, 5'd4, 1, 32'h99,       1, 0, 32'h0,        0, 0, 0};
        vecs[14] = '{0, 4'd6,  32'h103, 0, 5'd4, 1, 32'h99,       1, 0, 32'h0,        0, 0, 0};
        vecs[15] = '{1, 4'd0,  32'h100, 0, 5'd6, 1, 32'h55,       0, 0, 32'h0,        0, 0, 0};
        vecs[16] = '{1, 4'd5,  32'h101, 0, 5'd6, 1, 32'h55,       0, 0, 32'h0,        0, 0, 0};

        idle_inputs();
        rst = 1;
        in_wreg = 1; in_wdata = 32'hFFFF0000; in_wd = 5'd3;
        repeat (3) @(negedge clk);
        #1;
        chk("reset bus_req",   32'(bus_if.bus_req), 32'd0);
        chk("reset bus_addr",  bus_if.bus_addr, 32'd0);
        chk("reset bus_sel",   32'(bus_if.bus_sel), 32'd0);
        chk("reset bus_wdata", bus_if.bus_wdata, 32'd0);
        chk("reset bus_we",    32'(bus_if.bus_we), 32'd0);
        chk("reset stallreq",  32'(stallreq), 32'd0);
        chk("reset out_wreg",  32'(out_wreg), 32'd0);
        chk("reset out_wdata", out_wdata, 32'd0);
        chk("reset bus_err",   32'(bus_err), 32'd0);
        idle_inputs();
        @(negedge clk); rst = 0;

        // Single-cycle combinational behaviour in IDLE
        foreach (vecs[i]) begin
            @(negedge clk);
            flush = vecs[i].flush; mem_op = vecs[i].op; mem_addr = vecs[i].addr;
            llbit_in = vecs[i].llb; in_wd = vecs[i].wd; in_wreg = vecs[i].wreg;
            in_wdata = vecs[i].wdata; mem_sdata = 32'h01020304;
            #1;
            chk($sformatf("vec%0d stallreq", i), 32'(stallreq), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d out_wreg", i), 32'(out_wreg), 32'(vecs[i].e_wreg));
            if (vecs[i].e_wreg)
                chk($sformatf("vec%0d out_wdata", i), out_wdata, vecs[i].e_wdata);
            chk($sformatf("vec%0d out_wd", i), 32'(out_wd), 32'(vecs[i].wd));
            chk($sformatf("vec%0d adel", i), 32'(excp_adel), 32'(vecs[i].e_adel));
            chk($sformatf("vec%0d ades", i), 32'(excp_ades), 32'(vecs[i].e_ades));
            chk($sformatf("vec%0d llbit_we", i), 32'(out_llbit_we), 32'(vecs[i].e_llwe));
            chk($sformatf("vec%0d bus_req", i), 32'(bus_if.bus_req), 32'd0);
            #1 idle_inputs();
        end

        // Full transactions
        access("LW",  4'd5,  32'h100, 32'h0,      0, 1, 32'h11223344, 3, 0, 4'b1111, 32'h0,       1, 32'h11223344, 0, 0);
        access("LB",  4'd1,  32'h103, 32'h0,      0, 0, 32'h000000F0, 2, 0, 4'b0001, 32'h0,       1, 32'hFFFFFFF0, 0, 0);
        access("LBU", 4'd2,  32'h103, 32'h0,      0, 0, 32'h000000F0, 2, 0, 4'b0001, 32'h0,       1, 32'h000000F0, 0, 0);
        access("LH",  4'd3,  32'h100, 32'h0,      0, 0, 32'h80017F00, 2, 0, 4'b1100, 32'h0,       1, 32'hFFFF8001, 0, 0);
        access("LHU", 4'd4,  32'h102, 32'h0,      0, 2, 32'h80017F00, 4, 0, 4'b0011, 32'h0,       1, 32'h00007F00, 0, 0);
        access("SH",  4'd7,  32'h102, 32'hABCD,   0, 0, 32'h0,        2, 1, 4'b0011, 32'hABCDABCD, 0, 32'h0,       0, 0);
        access("SB",  4'd6,  32'h101, 32'h5A,     0, 0, 32'h0,        2, 1, 4'b0100, 32'h5A5A5A5A, 0, 32'h0,       0, 0);
        access("SW",  4'd8,  32'h10C, 32'hCAFE1234, 0, 0, 32'h0,      2, 1, 4'b1111, 32'hCAFE1234, 0, 32'h0,       0, 0);
        access("LL",  4'd9,  32'h104, 32'h0,      0, 0, 32'hCAFEF00D, 2, 0, 4'b1111, 32'h0,       1, 32'hCAFEF00D, 1, 1);
        access("SC",  4'd10, 32'h108, 32'h12345678, 1, 0, 32'h0,      2, 1, 4'b1111, 32'h12345678, 1, 32'h00000001, 1, 0);

        // Flush during BUSY -> DRAIN, result discarded, next op waits for IDLE
        @(negedge clk);
        mem_op = 4'd5; mem_addr = 32'h200; in_wd = 5'd4;
        @(negedge clk); #1;
        chk("drain busy req", 32'(bus_if.bus_req), 32'd1);
        flush = 1;
        @(negedge clk); #1;
        flush = 0; mem_op = 4'd0; in_wreg = 0;
        #1;
        chk("drain req held", 32'(bus_if.bus_req), 32'd1);
        chk("drain stall", 32'(stallreq), 32'd0);
        mem_op = 4'd5; mem_addr = 32'h300;
        #1;
        chk("drain new op stall", 32'(stallreq), 32'd1);
        chk("drain new op wreg", 32'(out_wreg), 32'd0);
        bus_if.bus_ack = 1; bus_if.bus_rdata = 32'hBAD0BAD0;
        @(negedge clk); bus_if.bus_ack = 0; #1;
        chk("drain exit req", 32'(bus_if.bus_req), 32'd0);
        chk("drain exit stall", 32'(stallreq), 32'd1);
        chk("drain discarded wreg", 32'(out_wreg), 32'd0);
        @(negedge clk); #1;
        chk("post drain req", 32'(bus_if.bus_req), 32'd1);
        chk("post drain addr", bus_if.bus_addr, 32'h300);
        bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h00000077;
        @(negedge clk); bus_if.bus_ack = 0; #1;
        chk("post drain stall", 32'(stallreq), 32'd0);
        chk("post drain wreg", 32'(out_wreg), 32'd1);
        chk("post drain wdata", out_wdata, 32'h00000077);
        idle_inputs();

        // Flush in DONE squashes the write-back
        @(negedge clk);
        mem_op = 4'd9; mem_addr = 32'h500;
        @(negedge clk); #1;
        bus_if.bus_ack = 1; bus_if.bus_rdata = 32'h9;
        @(negedge clk); bus_if.bus_ack = 0; flush = 1; #1;
        chk("flush done wreg", 32'(out_wreg), 32'd0);
        chk("flush done llbit_we", 32'(out_llbit_we), 32'd0);
        idle_inputs();

        // Timeout: no ack ever
        begin
            int  req_cnt = 0;
            bit  seen = 0;
            @(negedge clk);
            mem_op = 4'd5; mem_addr = 32'h400;
            for (int c = 0; c < 12 && !seen; c++) begin
                @(negedge clk); #1;
                if (bus_if.bus_req) req_cnt++;
                if (bus_err) begin
                    seen = 1;
                    chk("timeout req cycles", 32'(req_cnt), 32'd4);
                    chk("timeout bus_req", 32'(bus_if.bus_req), 32'd0);
                    chk("timeout wreg", 32'(out_wreg), 32'd0);
                    chk("timeout stall", 32'(stallreq), 32'd0);
                    idle_inputs();
                end
            end
            if (!seen) chk("timeout bus_err seen", 32'd0, 32'd1);
            @(negedge clk); #1;
            chk("timeout err one cycle", 32'(bus_err), 32'd0);
            chk("timeout no reissue", 32'(bus_if.bus_req), 32'd0);
        end

        // Reset mid-transaction
        @(negedge clk);
        mem_op = 4'd8; mem_addr = 32'h600; mem_sdata = 32'h1;
        @(negedge clk); #1;
        chk("rst busy req", 32'(bus_if.bus_req), 32'd1);
        rst = 1;
        @(negedge clk); #1;
        chk("rst drops req", 32'(bus_if.bus_req), 32'd0);
        chk("rst stall", 32'(stallreq), 32'd0);
        idle_inputs(); rst = 0;
        @(negedge clk); #1;
        chk("rst after idle req", 32'(bus_if.bus_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
